// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: memory-control bit positions, WB control width
// and MEM-stage FSM state encodings.
package mips_pkg;

    localparam int MEM_RD_BIT = 1;
    localparam int MEM_WR_BIT = 0;
    localparam int WB_W       = 4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    // Both-bits-set is meaningless; any access must be word aligned.
    function automatic logic is_illegal(input logic [1:0] ctrl, input logic [1:0] addr_lsb);
        return (ctrl == 2'b11) || ((ctrl != 2'b00) && (addr_lsb != 2'b00));
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; loads every cycle, a bubble forces the WB control to zero
// so the write-back stage commits nothing.
module mem_wb_reg
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bubble,
    input  logic [WB_W-1:0]   ctrl_in,
    input  logic [DATA_W-1:0] read_data_in,
    input  logic [DATA_W-1:0] alu_res_in,
    input  logic [4:0]        rd_in,
    output logic [WB_W-1:0]   wb_ctrl,
    output logic [DATA_W-1:0] wb_read_data,
    output logic [DATA_W-1:0] wb_alu_res,
    output logic [4:0]        wb_rd
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_ctrl      <= '0;
            wb_read_data <= '0;
            wb_alu_res   <= '0;
            wb_rd        <= '0;
        end else begin
            wb_ctrl      <= bubble ? '0 : ctrl_in;
            wb_read_data <= read_data_in;
            wb_alu_res   <= alu_res_in;
            wb_rd        <= rd_in;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: issues loads/stores to a variable-latency data memory over req/ack,
// stalls upstream while an access is outstanding and flags illegal/timed-out accesses.
module mem_access_stage
    import mips_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WB_W-1:0]   mem_wb_in,
    input  logic [1:0]        mem_ctrl,
    input  logic [DATA_W-1:0] alu_res,
    input  logic [DATA_W-1:0] write_data,
    input  logic [4:0]        rd_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              stall,
    output logic [WB_W-1:0]   wb_ctrl,
    output logic [DATA_W-1:0] wb_read_data,
    output logic [DATA_W-1:0] wb_alu_res,
    output logic [4:0]        wb_rd,
    output logic              mem_err
);

    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic [WB_W-1:0]   wb_q, wb_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [4:0]        rd_q, rd_d;
    logic              err_q, err_d;

    logic              access, illegal, timeout;
    logic              stall_c, bubble;
    logic [WB_W-1:0]   wbr_ctrl;
    logic [DATA_W-1:0] wbr_rdata, wbr_alu;
    logic [4:0]        wbr_rd;

    assign access  = (mem_ctrl != 2'b00);
    assign illegal = is_illegal(mem_ctrl, alu_res[1:0]);
    assign timeout = (cnt_q == CNT_W'(MAX_WAIT - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctrl_d    = ctrl_q;
        wb_d      = wb_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_d      = rd_q;
        err_d     = err_q;
        stall_c   = 1'b0;
        bubble    = 1'b0;
        wbr_ctrl  = mem_wb_in;
        wbr_rdata = '0;
        wbr_alu   = alu_res;
        wbr_rd    = rd_in;

        if (state_q == ST_IDLE) begin
            if (illegal) begin
                err_d  = 1'b1;
                bubble = 1'b1;
            end else if (access) begin
                stall_c = 1'b1;
                bubble  = 1'b1;
                ctrl_d  = mem_ctrl;
                wb_d    = mem_wb_in;
                addr_d  = alu_res;
                wdata_d = write_data;
                rd_d    = rd_in;
                cnt_d   = '0;
                state_d = ST_REQ;
            end
        end else begin
            wbr_ctrl = wb_q;
            wbr_alu  = addr_q;
            wbr_rd   = rd_q;
            // An ack arriving on the timeout cycle still completes the access.
            if (dmem_ack) begin
                if (ctrl_q[MEM_RD_BIT]) begin
                    wbr_rdata = dmem_rdata;
                end
                cnt_d   = '0;
                state_d = ST_IDLE;
            end else if (timeout) begin
                err_d   = 1'b1;
                bubble  = 1'b1;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end else begin
                stall_c = 1'b1;
                bubble  = 1'b1;
                cnt_d   = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ctrl_q  <= '0;
            wb_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            wb_q    <= wb_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    // Stall is combinational from the inputs in IDLE, so mask it during reset.
    assign stall      = stall_c & ~rst;
    assign dmem_req   = (state_q == ST_REQ);
    assign dmem_we    = ctrl_q[MEM_WR_BIT];
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign mem_err    = err_q;

    mem_wb_reg #(
        .DATA_W (DATA_W)
    ) u_mem_wb_reg (
        .clk          (clk),
        .rst          (rst),
        .bubble       (bubble),
        .ctrl_in      (wbr_ctrl),
        .read_data_in (wbr_rdata),
        .alu_res_in   (wbr_alu),
        .rd_in        (wbr_rd),
        .wb_ctrl      (wb_ctrl),
        .wb_read_data (wb_read_data),
        .wb_alu_res   (wb_alu_res),
        .wb_rd        (wb_rd)
    );

endmodule
